// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_write_arbiter: arbitrates pipeline writeback and a FIFO of         |
// | multi-cycle results onto one registered register-file write port.          |
// | Optional starvation guard: define RFA_STARVE_GUARD_EN.   Revision: 1.0      |
// +----------------------------------------------------------------------------+
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_we,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_wd,
  output logic        p_stall,
  input  logic        m_valid,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_wd,
  output logic        m_ready,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        busy,
  output logic [31:0] pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_mem_rd [DEPTH];
  logic [31:0]   r_mem_wd [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_p_req;
  logic w_force;
  logic w_grant_p;

  // Readiness comes from the registered count only: a full FIFO is never
  // credited with a same-cycle pop.
  assign w_full  = (r_count == CW'(DEPTH));
  assign m_ready = !w_full && !reset;
  assign busy    = (r_count != '0);
  assign w_push  = m_valid && m_ready && (m_rd != 5'd0);
  assign w_p_req = p_we && (p_rd != 5'd0);

`ifdef RFA_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  assign w_force = busy && w_p_req && (r_starve == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!busy || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + SW'(1);
    end
  end
`else
  logic w_unused_starve;
  assign w_unused_starve = (STARVE_LIMIT > 0);
  assign w_force         = 1'b0;
`endif

  assign p_stall   = w_force;
  assign w_grant_p = w_p_req && !w_force;
  assign w_pop     = busy && !w_grant_p;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr] <= m_rd;
      r_mem_wd[r_wptr] <= m_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      we3     <= 1'b0;
      a3      <= 5'd0;
      wd3     <= 32'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      we3 <= w_grant_p || w_pop;
      if (w_grant_p) begin
        a3  <= p_rd;
        wd3 <= p_wd;
      end else if (w_pop) begin
        a3  <= r_mem_rd[r_rptr];
        wd3 <= r_mem_wd[r_rptr];
      end
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - r_rptr} < r_count) pend_mask[r_mem_rd[i]] = 1'b1;
    end
  end

endmodule
`default_nettype wire
